// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and control outputs of the stopwatch control FSM
interface stopwatch_ctrl_if;
    logic       btn_go;
    logic       btn_lap;
    logic       run;
    logic       clr;
    logic       lap_hold;
    logic [1:0] state;
    modport master (output btn_go, btn_lap, input run, clr, lap_hold, state);
    modport slave  (input btn_go, btn_lap, output run, clr, lap_hold, state);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/long-press-clear control FSM; LAP state enabled by macro LAP_MODE_EN
module stopwatch_ctrl #(
    parameter int LONG_PRESS_TICKS = 100_000_000,
    parameter int CNT_W            = 27
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_prev_q, clr_q, clr_d, go_rise, long_press;
`ifdef LAP_MODE_EN
    logic             lap_prev_q, lap_rise;
    assign lap_rise = sw.btn_lap & ~lap_prev_q;
`endif
    assign go_rise    = sw.btn_go & ~go_prev_q;
    assign long_press = (state_q == PAUSE) && sw.btn_lap && (cnt_q == CNT_W'(LONG_PRESS_TICKS - 1));
    // next state; go edge always takes priority over lap events
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_rise) state_d = RUN;
            RUN: begin
                if (go_rise) state_d = PAUSE;
`ifdef LAP_MODE_EN
                else if (lap_rise) state_d = LAP;
`endif
            end
            PAUSE: begin
                if (go_rise) state_d = RUN;
                else if (long_press) state_d = IDLE;
            end
`ifdef LAP_MODE_EN
            LAP: begin
                if (go_rise) state_d = PAUSE;
                else if (lap_rise) state_d = RUN;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    // long-press counter runs only while LAP is held in PAUSE and saturates at the threshold via the clear
    always_comb begin
        clr_d = long_press && !go_rise;
        cnt_d = (state_q == PAUSE && sw.btn_lap && !go_rise && !long_press) ? cnt_q + 1'b1 : '0;
    end
    // state, counter, clear pulse and edge-detect history; history resets high to suppress held buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clr_q     <= 1'b0;
            go_prev_q <= 1'b1;
`ifdef LAP_MODE_EN
            lap_prev_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_q     <= clr_d;
            go_prev_q <= sw.btn_go;
`ifdef LAP_MODE_EN
            lap_prev_q <= sw.btn_lap;
`endif
        end
    end
    assign sw.state = state_q;
    assign sw.run   = (state_q == RUN) || (state_q == LAP);
    assign sw.clr   = clr_q;
`ifdef LAP_MODE_EN
    assign sw.lap_hold = (state_q == LAP);
`else
    assign sw.lap_hold = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl with an 8-cycle long press
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    stopwatch_ctrl_if swif();
    stopwatch_ctrl #(.LONG_PRESS_TICKS(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .sw(swif.slave));
    always #5 clk = ~clk;
    // expected {state[1:0], run, clr, lap_hold}
    localparam logic [4:0] SI = 5'b00000, SR = 5'b01100, SP = 5'b10000, SC = 5'b00010;
`ifdef LAP_MODE_EN
    localparam logic [4:0] SL = 5'b11101;
`else
    localparam logic [4:0] SL = 5'b01100;
`endif
    logic [7:0] stim[$];
    logic [4:0] sb[$];
    function automatic logic [7:0] mk(input logic r, input logic g, input logic l, input logic [4:0] e);
        return {r, g, l, e};
    endfunction
    task automatic to_pause();
        stim.push_back(mk(1, 0, 0, SI));
        stim.push_back(mk(0, 0, 0, SI));
        stim.push_back(mk(0, 1, 0, SR));
        stim.push_back(mk(0, 0, 0, SR));
        stim.push_back(mk(0, 1, 0, SP));
        stim.push_back(mk(0, 0, 0, SP));
    endtask
    task automatic test_reset();
        stim.push_back(mk(1, 1, 0, SI));
        stim.push_back(mk(1, 1, 0, SI));
        for (int i = 0; i < 5; i++) stim.push_back(mk(0, 1, 0, SI));
        stim.push_back(mk(0, 0, 0, SI));
        stim.push_back(mk(0, 1, 0, SR));
        stim.push_back(mk(0, 0, 0, SR));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL reset step %0d: got %b expected %b", n, got, e); end
        end
    endtask
    task automatic test_go_toggle();
        stim.push_back(mk(1, 0, 0, SI));
        stim.push_back(mk(0, 0, 0, SI));
        stim.push_back(mk(0, 1, 0, SR));
        stim.push_back(mk(0, 0, 0, SR));
        stim.push_back(mk(0, 1, 0, SP));
        stim.push_back(mk(0, 0, 0, SP));
        stim.push_back(mk(0, 1, 0, SR));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL go_toggle step %0d: got %b expected %b", n, got, e); end
        end
    endtask
    task automatic test_lap();
        stim.push_back(mk(1, 0, 0, SI));
        stim.push_back(mk(0, 0, 0, SI));
        stim.push_back(mk(0, 1, 0, SR));
        stim.push_back(mk(0, 0, 0, SR));
        stim.push_back(mk(0, 0, 1, SL));
        stim.push_back(mk(0, 0, 0, SL));
        stim.push_back(mk(0, 0, 1, SR));
        stim.push_back(mk(0, 0, 0, SR));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL lap step %0d: got %b expected %b", n, got, e); end
        end
    endtask
    task automatic test_long_press();
        to_pause();
        for (int i = 0; i < 7; i++) stim.push_back(mk(0, 0, 1, SP));
        stim.push_back(mk(0, 0, 0, SP));
        stim.push_back(mk(0, 0, 0, SP));
        for (int i = 0; i < 7; i++) stim.push_back(mk(0, 0, 1, SP));
        stim.push_back(mk(0, 0, 1, SC));
        stim.push_back(mk(0, 0, 1, SI));
        stim.push_back(mk(0, 0, 1, SI));
        stim.push_back(mk(0, 0, 0, SI));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL long_press step %0d: got %b expected %b", n, got, e); end
        end
    endtask
    task automatic test_go_wins();
        to_pause();
        for (int i = 0; i < 7; i++) stim.push_back(mk(0, 0, 1, SP));
        stim.push_back(mk(0, 1, 1, SR));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL go_wins step %0d: got %b expected %b", n, got, e); end
        end
        checks++;
        if (dut.cnt_q !== 4'd0) begin fails++; $display("FAIL go_wins counter: got %0d expected 0", dut.cnt_q); end
        {swif.btn_go, swif.btn_lap} = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (swif.clr !== 1'b0) begin fails++; $display("FAIL go_wins clr: got %b expected 0", swif.clr); end
    endtask
    task automatic test_reset_mid_press();
        to_pause();
        for (int i = 0; i < 5; i++) stim.push_back(mk(0, 0, 1, SP));
        stim.push_back(mk(1, 0, 1, SI));
        stim.push_back(mk(0, 0, 1, SI));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL reset_mid_press step %0d: got %b expected %b", n, got, e); end
        end
        checks++;
        if (dut.cnt_q !== 4'd0) begin fails++; $display("FAIL reset_mid_press counter: got %0d expected 0", dut.cnt_q); end
    endtask
    task automatic test_back_to_back();
        stim.push_back(mk(1, 0, 0, SI));
        stim.push_back(mk(0, 0, 0, SI));
        stim.push_back(mk(0, 1, 0, SR));
        stim.push_back(mk(0, 0, 0, SR));
        stim.push_back(mk(0, 0, 1, SL));
        stim.push_back(mk(0, 0, 0, SL));
        stim.push_back(mk(0, 1, 1, SP));
        stim.push_back(mk(0, 0, 0, SP));
        for (int n = 0; stim.size() > 0; n++) begin
            logic [7:0] s; logic [4:0] e, got;
            s = stim.pop_front(); {rst, swif.btn_go, swif.btn_lap} = s[7:5]; sb.push_back(s[4:0]);
            @(posedge clk); #1;
            e = sb.pop_front(); got = {swif.state, swif.run, swif.clr, swif.lap_hold}; checks++;
            if (got !== e) begin fails++; $display("FAIL back_to_back step %0d: got %b expected %b", n, got, e); end
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        swif.btn_go = 1'b1;
        swif.btn_lap = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_go_toggle();
        test_lap();
        test_long_press();
        test_go_wins();
        test_reset_mid_press();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
